// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
//   state_t        : loader FSM states
//   LEN_BYTES      : bytes in the little-endian word-count header
//   CHK_BYTES      : bytes in the trailing checksum field
//   CHK_INIT       : checksum accumulator start value (XOR identity)
//   BYTES_PER_WORD : stream bytes packed into one program word
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam int          LEN_BYTES      = 2;
    localparam int          CHK_BYTES      = 1;
    localparam logic [7:0]  CHK_INIT       = 8'h00;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    // States in which a stream byte may be consumed.
    function automatic logic takes_bytes(state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHECK);
    endfunction

    // States that count as a load in progress.
    function automatic logic in_load(state_t s);
        return takes_bytes(s) || (s == S_WRITE);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
//   byte_valid_i / byte_data_i / byte_ready_o : byte stream handshake
//   mem_we_o / mem_addr_o / mem_wdata_o       : one-word write port
// slave  : the loader side
// master : the environment (byte source + program memory)
interface program_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  byte_valid_i;
    logic [7:0]            byte_data_i;
    logic                  byte_ready_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;

    modport slave (
        input  byte_valid_i, byte_data_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output byte_valid_i, byte_data_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/loader_word_packer.sv
// Assembles little-endian stream bytes into program words.
//   clk, reset  : clock, async active-high reset
//   clear       : restart at byte 0 (new load)
//   push        : a data byte is consumed this cycle
//   byte_i      : the data byte
//   word_full_o : this push completes a word
//   word_o      : assembled word, valid together with word_full_o
module loader_word_packer
    import program_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        push,
    input  logic [7:0]                  byte_i,
    output logic                        word_full_o,
    output logic [8*BYTES_PER_WORD-1:0] word_o
);
    logic [BYTE_IDX_W-1:0]           idx_q;
    // Only the lower bytes are stored; the top byte is taken straight from
    // the stream so the full word is ready in the cycle the last byte lands.
    logic [8*(BYTES_PER_WORD-1)-1:0] low_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            low_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
            low_q <= '0;
        end else if (push) begin
            idx_q <= idx_q + 1'b1;
            for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
                if (idx_q == BYTE_IDX_W'(i)) low_q[8*i +: 8] <= byte_i;
            end
        end
    end

    assign word_full_o = push && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign word_o      = {byte_i, low_q};
endmodule

// File: rtl/program_loader.sv
// Program image loader: takes a framed byte stream (LEN_LO, LEN_HI, 4*N data
// bytes, XOR checksum) and writes it word by word into program memory,
// holding the CPU in reset until a complete, checksum-valid image is in.
//   clk, reset   : clock, async active-high reset
//   start_i      : begin a load (only from IDLE, DONE, ERR)
//   bus          : byte stream in, memory write port out
//   cpu_hold_o   : keep CPU in reset
//   busy_o       : load in progress
//   done_o       : image loaded and verified
//   error_o      : length or checksum failure
//   word_count_o : words written in the current load
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    program_loader_if.slave   bus,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [15:0]       word_count_o
);
    localparam logic [15:0] MAX_WORDS = 16'(MEMORY_DEPTH);

    state_t                      state_q, state_d;
    logic [15:0]                 len_q;
    logic [15:0]                 word_idx_q;
    logic [7:0]                  chk_q;
    logic                        accept;
    logic                        start_go;
    logic                        word_full;
    logic [8*BYTES_PER_WORD-1:0] word;
    logic [15:0]                 len_full;

    assign accept       = bus.byte_valid_i && bus.byte_ready_o;
    assign start_go     = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign len_full     = {bus.byte_data_i, len_q[7:0]};
    assign word_count_o = word_idx_q;

    loader_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_go),
        .push        (accept && (state_q == S_DATA)),
        .byte_i      (bus.byte_data_i),
        .word_full_o (word_full),
        .word_o      (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_i) state_d = S_LEN_LO;
            S_LEN_LO: if (accept) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0)          state_d = S_CHECK;
                    else if (len_full > MAX_WORDS)  state_d = S_ERR;
                    else                            state_d = S_DATA;
                end
            end
            S_DATA:  if (word_full) state_d = S_WRITE;
            S_WRITE: state_d = (word_idx_q + 16'd1 == len_q) ? S_CHECK : S_DATA;
            S_CHECK: if (accept) state_d = (bus.byte_data_i == chk_q) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Frame bookkeeping: length, running checksum, word index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            chk_q      <= CHK_INIT;
            word_idx_q <= '0;
        end else if (start_go) begin
            len_q      <= '0;
            chk_q      <= CHK_INIT;
            word_idx_q <= '0;
        end else begin
            // The checksum byte itself is compared, never folded in.
            if (accept && (state_q != S_CHECK)) chk_q <= chk_q ^ bus.byte_data_i;
            if (accept && (state_q == S_LEN_LO)) len_q[7:0]  <= bus.byte_data_i;
            if (accept && (state_q == S_LEN_HI)) len_q[15:8] <= bus.byte_data_i;
            if (state_q == S_WRITE) word_idx_q <= word_idx_q + 16'd1;
        end
    end

    // Outputs are decoded from the next state so they line up with the
    // state register rather than lagging it by a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.byte_ready_o <= 1'b0;
            bus.mem_we_o     <= 1'b0;
            bus.mem_addr_o   <= BASE_ADDR;
            bus.mem_wdata_o  <= '0;
            cpu_hold_o       <= 1'b1;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            error_o          <= 1'b0;
        end else begin
            bus.byte_ready_o <= takes_bytes(state_d);
            bus.mem_we_o     <= (state_d == S_WRITE);
            if (state_d == S_WRITE) begin
                bus.mem_addr_o  <= BASE_ADDR + DATA_WIDTH'({word_idx_q, 2'b00});
                bus.mem_wdata_o <= DATA_WIDTH'(word);
            end
            cpu_hold_o <= (state_d != S_DONE);
            busy_o     <= in_load(state_d);
            done_o     <= (state_d == S_DONE);
            error_o    <= (state_d == S_ERR);
        end
    end
endmodule
